rv32_ram_arbiter: RTL and testbench

//  Shares the single-port 32-bit word RAM between two masters:
//   - m0: the rv32 core data/instruction port.
//   - m1: a secondary master (program loader / debug / DMA).
//  Per-port req/gnt handshake; a bounded round-robin policy guarantees neither port starves.

---
 rtl/rv32_pkg.sv | 18 +
 rtl/rv32_arb_pick.sv | 32 +++
 rtl/rv32_ram_arbiter.sv | 128 ++++++++++++
 tb/tb_rv32_ram_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rv32_pkg
// Brief   : Shared types and constants for the rv32 RAM arbiter slice.
// Revision: 1.0
// ============================================================================
package rv32_pkg;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } arb_owner_e;

  localparam logic [3:0] STRB_WORD = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/rv32_arb_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rv32_arb_pick
// Brief   : Combinational two-way winner select with bounded burst priority.
// Revision: 1.0
// ============================================================================
module rv32_arb_pick
  import rv32_pkg::*;
(
  input  logic [1:0]  req,
  input  arb_owner_e  last_owner,
  input  logic        burst_full,
  output logic [1:0]  gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Contention: keep the current owner until its burst is used up.
      2'b11: begin
        if (!burst_full) gnt = (last_owner == OWN_M0) ? 2'b01 : 2'b10;
        else             gnt = (last_owner == OWN_M0) ? 2'b10 : 2'b01;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv32_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rv32_ram_arbiter
// Brief   : Shares one single-port word RAM between the core (m0) and a
//           secondary master (m1); routes read data back to the issuer.
// Revision: 1.0
// ============================================================================
module rv32_ram_arbiter
  import rv32_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [3:0]            m0_strobe,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [3:0]            m1_strobe,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,

  output logic                  ram_wr_en,
  output logic [3:0]            ram_wr_strobe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_data_in,
  input  logic [31:0]           ram_data_out
);

  localparam int              CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_BURST - 1);

  arb_owner_e       r_last_owner;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             r_burst_act;
  logic             r_rd_pend;
  arb_owner_e       r_rd_owner;

  logic [1:0]       w_pick;
  logic [1:0]       w_gnt;
  logic             w_any;
  logic             w_we;
  logic             w_burst_full;
  arb_owner_e       w_gnt_port;

  // A burst only continues across back-to-back grants; after an idle cycle
  // (or reset) a tie goes to the port that did not own the bus last.
  assign w_burst_full = !r_burst_act || (r_burst_cnt >= C_CNT_MAX);

  rv32_arb_pick u_pick (
    .req        ({m1_req, m0_req}),
    .last_owner (r_last_owner),
    .burst_full (w_burst_full),
    .gnt        (w_pick)
  );

  assign w_gnt      = w_pick & {2{reset_n}};
  assign w_any      = |w_gnt;
  assign w_gnt_port = w_gnt[1] ? OWN_M1 : OWN_M0;
  assign w_we       = w_gnt[1] ? m1_we : m0_we;

  assign m0_gnt    = w_gnt[0];
  assign m1_gnt    = w_gnt[1];
  assign m0_rvalid = r_rd_pend && (r_rd_owner == OWN_M0);
  assign m1_rvalid = r_rd_pend && (r_rd_owner == OWN_M1);
  assign m0_rdata  = ram_data_out;
  assign m1_rdata  = ram_data_out;

  always_comb begin
    ram_wr_en     = 1'b0;
    ram_wr_strobe = 4'b0000;
    ram_addr      = m0_addr;
    ram_data_in   = m0_wdata;
    if (!reset_n) begin
      ram_addr    = '0;
      ram_data_in = '0;
    end else if (w_gnt[1]) begin
      ram_wr_en     = m1_we;
      ram_wr_strobe = m1_strobe;
      ram_addr      = m1_addr;
      ram_data_in   = m1_wdata;
    end else if (w_gnt[0]) begin
      ram_wr_en     = m0_we;
      ram_wr_strobe = m0_strobe;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_owner <= OWN_M1;
      r_burst_cnt  <= '0;
      r_burst_act  <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= OWN_M0;
    end else begin
      r_rd_pend <= w_any && !w_we;
      if (w_any && !w_we) r_rd_owner <= w_gnt_port;

      if (!w_any) begin
        r_burst_cnt <= '0;
        r_burst_act <= 1'b0;
      end else begin
        r_burst_act <= 1'b1;
        if (w_gnt_port == r_last_owner) begin
          if (r_burst_cnt < C_CNT_MAX) r_burst_cnt <= r_burst_cnt + CNT_W'(1);
        end else begin
          r_last_owner <= w_gnt_port;
          r_burst_cnt  <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_rv32_ram_arbiter
// Brief   : Directed vector bench for rv32_ram_arbiter with a behavioural RAM.
// Revision: 1.0
// ============================================================================
module tb_rv32_ram_arbiter;
  import rv32_pkg::*;

  localparam int ADDR_WIDTH = 16;
  localparam int MAX_BURST  = 4;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  m0_req, m0_we, m1_req, m1_we;
  logic [3:0]            m0_strobe, m1_strobe;
  logic [ADDR_WIDTH-1:0] m0_addr, m1_addr;
  logic [31:0]           m0_wdata, m1_wdata;
  logic                  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0]           m0_rdata, m1_rdata;
  logic                  ram_wr_en;
  logic [3:0]            ram_wr_strobe;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_data_in;
  logic [31:0]           ram_data_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv32_ram_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_strobe(m0_strobe), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_strobe(m1_strobe), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_wr_en(ram_wr_en), .ram_wr_strobe(ram_wr_strobe), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // Behavioural single-port RAM: byte-strobed write, one-cycle read latency.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (!reset_n) begin
      mem[8'h01] <= 32'hCAFE0001;
      mem[8'h02] <= 32'hCAFE0002;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'h11223344;
      mem[8'h30] <= 32'h00000000;
    end else if (ram_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_wr_strobe[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_data_in[8*b +: 8];
    end
    ram_data_out <= mem[ram_addr[7:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic we0, input logic [3:0] s0,
                       input logic [15:0] a0, input logic [31:0] d0,
                       input logic r1, input logic we1, input logic [3:0] s1,
                       input logic [15:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_we = we0; m0_strobe = s0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = we1; m1_strobe = s1; m1_addr = a1; m1_wdata = d1;
  endtask

  typedef struct {
    string       name;
    logic        r0, we0; logic [3:0] s0; logic [15:0] a0; logic [31:0] d0;
    logic        r1, we1; logic [3:0] s1; logic [15:0] a1; logic [31:0] d1;
    logic        eg0, eg1, ewe; logic [3:0] es; logic [15:0] ea; logic [31:0] ed;
    logic        ev0, ev1; logic [31:0] erd;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [9:0] burst_pat;
    int         wait0, wait1, max_wait;

    vecs[0]  = '{"rd0_0010",   1'b1,1'b0,4'h0,16'h0010,32'h0,        1'b0,1'b0,4'h0,16'h0000,32'h0,
                 1'b1,1'b0,1'b0,4'h0,16'h0010,32'h0,        1'b0,1'b0,32'h0};
    vecs[1]  = '{"idle_hold",  1'b0,1'b0,4'h0,16'h0033,32'h55,       1'b0,1'b0,4'h0,16'h0000,32'h0,
                 1'b0,1'b0,1'b0,4'h0,16'h0033,32'h55,       1'b1,1'b0,32'hDEADBEEF};
    vecs[2]  = '{"wr1_0020",   1'b0,1'b0,4'h0,16'h0000,32'h0,        1'b1,1'b1,4'b0100,16'h0020,32'h00AB0000,
                 1'b0,1'b1,1'b1,4'b0100,16'h0020,32'h00AB0000, 1'b0,1'b0,32'h0};
    vecs[3]  = '{"rd0_0020",   1'b1,1'b0,4'h0,16'h0020,32'h0,        1'b0,1'b0,4'h0,16'h0000,32'h0,
                 1'b1,1'b0,1'b0,4'h0,16'h0020,32'h0,        1'b0,1'b0,32'h0};
    vecs[4]  = '{"rd0_0001",   1'b1,1'b0,4'h0,16'h0001,32'h0,        1'b0,1'b0,4'h0,16'h0000,32'h0,
                 1'b1,1'b0,1'b0,4'h0,16'h0001,32'h0,        1'b1,1'b0,32'h11AB3344};
    vecs[5]  = '{"rd1_0002",   1'b0,1'b0,4'h0,16'h0000,32'h0,        1'b1,1'b0,4'h0,16'h0002,32'h0,
                 1'b0,1'b1,1'b0,4'h0,16'h0002,32'h0,        1'b1,1'b0,32'hCAFE0001};
    vecs[6]  = '{"idle2",      1'b0,1'b0,4'h0,16'h0000,32'h0,        1'b0,1'b0,4'h0,16'h0000,32'h0,
                 1'b0,1'b0,1'b0,4'h0,16'h0000,32'h0,        1'b0,1'b1,32'hCAFE0002};
    vecs[7]  = '{"wr0_0030",   1'b1,1'b1,STRB_WORD,16'h0030,32'h12345678, 1'b0,1'b0,4'h0,16'h0000,32'h0,
                 1'b1,1'b0,1'b1,STRB_WORD,16'h0030,32'h12345678, 1'b0,1'b0,32'h0};
    vecs[8]  = '{"tie_burst",  1'b1,1'b0,4'h0,16'h0030,32'h0,        1'b1,1'b0,4'h0,16'h0002,32'h0,
                 1'b1,1'b0,1'b0,4'h0,16'h0030,32'h0,        1'b0,1'b0,32'h0};
    vecs[9]  = '{"tie_burst2", 1'b1,1'b0,4'h0,16'h0010,32'h0,        1'b1,1'b0,4'h0,16'h0002,32'h0,
                 1'b1,1'b0,1'b0,4'h0,16'h0010,32'h0,        1'b1,1'b0,32'h12345678};
    vecs[10] = '{"rd1_wait",   1'b0,1'b0,4'h0,16'h0000,32'h0,        1'b1,1'b0,4'h0,16'h0002,32'h0,
                 1'b0,1'b1,1'b0,4'h0,16'h0002,32'h0,        1'b1,1'b0,32'hDEADBEEF};
    vecs[11] = '{"idle3",      1'b0,1'b0,4'h0,16'h0000,32'h0,        1'b0,1'b0,4'h0,16'h0000,32'h0,
                 1'b0,1'b0,1'b0,4'h0,16'h0000,32'h0,        1'b0,1'b1,32'hCAFE0002};

    // Reset held with both masters requesting (m1 as a write).
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 4'h0, 16'h0010, 32'h0, 1'b1, 1'b1, 4'hF, 16'h0002, 32'hFFFFFFFF);
    repeat (2) @(negedge clk);
    chk("rst_gnt0", {31'd0, m0_gnt}, 32'd0);
    chk("rst_gnt1", {31'd0, m1_gnt}, 32'd0);
    chk("rst_wr_en", {31'd0, ram_wr_en}, 32'd0);
    chk("rst_strobe", {28'd0, ram_wr_strobe}, 32'd0);
    chk("rst_addr", {16'd0, ram_addr}, 32'd0);
    chk("rst_data_in", ram_data_in, 32'd0);
    chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);

    // Release with both still requesting reads: continuous contention.
    @(posedge clk); #1;
    m1_we = 1'b0;
    reset_n = 1'b1;
    burst_pat = 10'b00_1111_0000;
    wait0 = 0; wait1 = 0; max_wait = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("burst%0d_gnt0", c), {31'd0, m0_gnt}, {31'd0, ~burst_pat[c]});
      chk($sformatf("burst%0d_gnt1", c), {31'd0, m1_gnt}, {31'd0, burst_pat[c]});
      wait0 = m0_gnt ? 0 : wait0 + 1;
      wait1 = m1_gnt ? 0 : wait1 + 1;
      if (wait0 > max_wait) max_wait = wait0;
      if (wait1 > max_wait) max_wait = wait1;
      @(posedge clk); #1;
    end
    chk("burst_max_wait_bounded", {31'd0, max_wait <= MAX_BURST}, 32'd1);

    // Reset asserted the cycle after a read grant drops the pending rvalid.
    drive(1'b0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 4'h0, 16'h0010, 32'h0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    @(negedge clk);
    chk("rstrd_gnt0", {31'd0, m0_gnt}, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    m0_req  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rstrd_rvalid0_%0d", c), {31'd0, m0_rvalid}, 32'd0);
      @(posedge clk); #1;
    end
    drive(1'b1, 1'b0, 4'h0, 16'h0010, 32'h0, 1'b1, 1'b0, 4'h0, 16'h0002, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rstrd_rvalid0_rel", {31'd0, m0_rvalid}, 32'd0);
    chk("rstrd_tie_gnt0", {31'd0, m0_gnt}, 32'd1);
    chk("rstrd_tie_gnt1", {31'd0, m1_gnt}, 32'd0);

    // Clean reset, then the cycle-by-cycle vector table.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].r0, vecs[i].we0, vecs[i].s0, vecs[i].a0, vecs[i].d0,
            vecs[i].r1, vecs[i].we1, vecs[i].s1, vecs[i].a1, vecs[i].d1);
      @(negedge clk);
      chk({vecs[i].name, "_gnt0"},    {31'd0, m0_gnt},        {31'd0, vecs[i].eg0});
      chk({vecs[i].name, "_gnt1"},    {31'd0, m1_gnt},        {31'd0, vecs[i].eg1});
      chk({vecs[i].name, "_wr_en"},   {31'd0, ram_wr_en},     {31'd0, vecs[i].ewe});
      chk({vecs[i].name, "_strobe"},  {28'd0, ram_wr_strobe}, {28'd0, vecs[i].es});
      chk({vecs[i].name, "_addr"},    {16'd0, ram_addr},      {16'd0, vecs[i].ea});
      chk({vecs[i].name, "_data_in"}, ram_data_in,            vecs[i].ed);
      chk({vecs[i].name, "_rvalid0"}, {31'd0, m0_rvalid},     {31'd0, vecs[i].ev0});
      chk({vecs[i].name, "_rvalid1"}, {31'd0, m1_rvalid},     {31'd0, vecs[i].ev1});
      if (vecs[i].ev0) chk({vecs[i].name, "_rdata0"}, m0_rdata, vecs[i].erd);
      if (vecs[i].ev1) chk({vecs[i].name, "_rdata1"}, m1_rdata, vecs[i].erd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
